log_approx_div: RTL and testbench
=================================

Name: log_approx_div

Overview:
- Pipelined approximate signed divider using the Mitchell logarithm. It is the inverse of the team's truncated log multipliers.
- Dividend and divisor each go through the same steps as the multiplier operands: ones-complement magnitude, leading-one detection, and a 4-bit truncated mantissa with its LSB forced to 1.
- The two log words are subtracted, then an antilog shifter produces the quotient.
- Sits downstream of the multiplier datapath, for normalisation and rescaling of products. Uses a valid/ready stream on both sides.

Parameters:
- W_A, 32, dividend width (two's-complement input).
- W_B, 16, divisor width.
- W_Q, 16, quotient width.
- F, 4, mantissa fraction bits kept after the leading one.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- in_a  in  W_A  dividend
- in_b  in  W_B  divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_q  out  W_Q  quotient; ones-complement encoded when negative
- out_div0  out  1  divisor magnitude was zero
- out_sat  out  1  quotient saturated

Behaviour:
- Interface decision: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all stage-valid bits 0, out_valid 0, out_q 0, out_div0 0, out_sat 0. in_ready is 1 once reset deasserts.
- Reset mid-operation discards every in-flight result; nothing is emitted afterwards for those operands.
- Pipeline: three register stages, S1, S2, S3. Latency from accept to out_valid is 3 cycles when there is no backpressure.
- Stage advance rule: a stage loads when it is empty or its downstream stage advances.
- in_ready = S1 empty or S1 advancing. It is combinational from out_ready through the stage chain.
- With out_ready held high, throughput is 1 result per cycle.
- Handshakes: transfer occurs on valid & ready. While out_valid is high and out_ready is low, out_q, out_div0 and out_sat hold stable.
- S1, magnitude and log encoding:
  - mag = x XOR {sign}. Consequence: an input of -1 maps to magnitude 0.
  - k = index of the leading one.
  - f = the F bits below the leading one, truncated, zero-padded when fewer than F exist, with the LSB forced to 1.
  - Log word = {k, f}: 5+4 bits for the dividend, 4+4 bits for the divisor.
  - zero_a / zero_b flags are registered; sign_q = a[W_A-1] ^ b[W_B-1].
- S2, log subtract: L = log_a - log_b as a 10-bit signed value. A mantissa borrow propagates into k. kL = L[9:4], fL = L[3:0].
- S3, antilog and result encoding:
  - If kL < 0: mag_q = 0.
  - Else if kL >= W_Q-1: mag_q = 2^(W_Q-1)-1 and sat = 1.
  - Else: mag_q = ({1, fL} << kL) >> F, truncated.
  - out_q = sign_q ? ~mag_q : mag_q.
- Special cases, in priority order:
  - zero_b: mag_q = 2^(W_Q-1)-1, sign = sign of a, div0 = 1, sat = 1.
  - else zero_a: out_q = 0, all flags 0.
- Ordering: results emerge strictly in acceptance order; there is no reordering or dropping.

Optional Feature:
- Macro LOG_DIV_ROUND_EN.
- Defined: the antilog keeps one guard bit below the truncation point and adds it (round half up). For kL = -1, mag_q = 1. A round carry that reaches 2^(W_Q-1) saturates and sets sat.
- Undefined: pure truncation as specified in Behaviour.

Decomposition:
- Package log_div_pkg holds the shared definitions:
  - width constants W_A, W_B, W_Q, F;
  - the log-word widths;
  - a typedef for the 10-bit signed log difference;
  - the saturation constant.
- One sub-module, log_div_lod: a parameterised leading-one detector and encoder returning k, the truncated/forced mantissa and a zero flag. It is instantiated twice, for the dividend and the divisor.

Test Plan:
- a=100, b=10, out_ready=1 -> out_q=10, out_div0=0, out_sat=0, 3 cycles after accept.
- a=1000, b=3 -> out_q=352 (approximation of 333); a=3, b=10 -> out_q=0.
- a=-100, b=10 -> magnitude 99 gives the same log as 100; out_q=~10=0xFFF5.
- a=5, b=0 -> out_q=0x7FFF, div0=1, sat=1. a=-5, b=0 -> out_q=0x8000, div0=1. a=0x40000000, b=1 -> out_q=0x7FFF, sat=1, div0=0.
- Stream 6 operand pairs back-to-back, with out_ready low for 5 cycles mid-stream:
  - in_ready deasserts once all three stages are full;
  - outputs stay stable while stalled;
  - all 6 results appear in order with none lost or duplicated.
- Assert rst_n low with 2 results in flight -> out_valid=0 immediately; no stale results appear after release. With LOG_DIV_ROUND_EN defined, a=1, b=2 -> out_q=1.

Source files
------------

// File: rtl/log_div_pkg.sv
// log_div_pkg: shared widths, log-word types, stage payloads and saturation constant
// for the Mitchell-log approximate divider.
package log_div_pkg;
   localparam int W_A  = 32;
   localparam int W_B  = 16;
   localparam int W_Q  = 16;
   localparam int F    = 4;
   localparam int KA_W = $clog2(W_A);
   localparam int KB_W = $clog2(W_B);
   localparam int LA_W = KA_W + F;
   localparam int LB_W = KB_W + F;
   localparam int LD_W = 10;
   localparam int KL_W = LD_W - F;
   localparam int SH_W = $clog2(W_Q);
   localparam logic [W_Q-1:0] SAT_MAG = {1'b0, {(W_Q-1){1'b1}}};

   typedef logic signed [LD_W-1:0] ldiff_t;

   typedef struct packed {
      logic [LA_W-1:0] la;
      logic [LB_W-1:0] lb;
      logic            za;
      logic            zb;
      logic            sq;
      logic            sa;
   } s1_t;

   typedef struct packed {
      ldiff_t l;
      logic   za;
      logic   zb;
      logic   sq;
      logic   sa;
   } s2_t;

   typedef struct packed {
      logic [W_Q-1:0] q;
      logic           div0;
      logic           sat;
   } s3_t;
endpackage

// File: rtl/log_div_lod.sv
// log_div_lod: leading-one detector returning the exponent, the truncated
// mantissa with its LSB forced to 1, and a zero flag.
module log_div_lod
   import log_div_pkg::*;
#(
   parameter int W  = 16,
   parameter int KW = 4
) (
   input  logic [W-1:0]  x_i,
   output logic [KW-1:0] k_o,
   output logic [F-1:0]  f_o,
   output logic          zero_o
);
   logic [W-1:0] n;

   // n is x normalised so the leading one sits at the MSB; zeros pad short inputs
   always_comb begin
      k_o = '0;
      n   = '0;
      for (int i = 0; i < W; i++)
         if (x_i[i]) begin
            k_o = KW'(i);
            n   = x_i << (W - 1 - i);
         end
      f_o    = {n[W-2 -: F-1], 1'b1};
      zero_o = ~|x_i;
   end
endmodule

// File: rtl/log_approx_div.sv
// log_approx_div: three-stage valid/ready Mitchell-log signed divider.
// Define LOG_DIV_ROUND_EN for round-half-up antilog instead of truncation.
module log_approx_div
   import log_div_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W_A-1:0] in_a,
   input  logic [W_B-1:0] in_b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W_Q-1:0] out_q,
   output logic           out_div0,
   output logic           out_sat
);
   s1_t                    s1_d, s1_q;
   s2_t                    s2_d, s2_q;
   s3_t                    s3_d, s3_q;
   logic                   v1_q, v2_q, v3_q, ld1, ld2, ld3;
   logic [KA_W-1:0]        ka;
   logic [KB_W-1:0]        kb;
   logic [F-1:0]           fa, fb, fl;
   logic                   za, zb, rnd, sat;
   logic signed [KL_W-1:0] kl;
   logic [SH_W-1:0]        sa;
   logic [W_Q+F:0]         sh;
   logic [W_Q-1:0]         m;

   assign ld3       = ~v3_q | out_ready;
   assign ld2       = ~v2_q | ld3;
   assign ld1       = ~v1_q | ld2;
   assign in_ready  = ld1;
   assign out_valid = v3_q;
   assign out_q     = s3_q.q;
   assign out_div0  = s3_q.div0;
   assign out_sat   = s3_q.sat;

   log_div_lod #(.W(W_A), .KW(KA_W)) u_lod_a (
      .x_i(in_a ^ {W_A{in_a[W_A-1]}}), .k_o(ka), .f_o(fa), .zero_o(za));
   log_div_lod #(.W(W_B), .KW(KB_W)) u_lod_b (
      .x_i(in_b ^ {W_B{in_b[W_B-1]}}), .k_o(kb), .f_o(fb), .zero_o(zb));

   assign s1_d = s1_t'{la: {ka, fa}, lb: {kb, fb}, za: za, zb: zb,
                       sq: in_a[W_A-1] ^ in_b[W_B-1], sa: in_a[W_A-1]};
   assign s2_d = s2_t'{l: ldiff_t'({1'b0, s1_q.la}) - ldiff_t'({2'b0, s1_q.lb}),
                       za: s1_q.za, zb: s1_q.zb, sq: s1_q.sq, sa: s1_q.sa};

   // Shift {1,fL,guard} by kL+1 so kL = -1 still yields a usable guard bit
   always_comb begin
      kl  = s2_q.l[LD_W-1:F];
      fl  = s2_q.l[F-1:0];
      sa  = SH_W'(kl + KL_W'(1));
      sh  = (W_Q+F+1)'({1'b1, fl, 1'b0}) << sa;
`ifdef LOG_DIV_ROUND_EN
      rnd = sh[F+1];
`else
      rnd = 1'b0;
`endif
      m   = {1'b0, sh[W_Q+F:F+2]} + W_Q'(rnd);
      sat = m[W_Q-1] | (int'(kl) >= W_Q - 1);
      if (int'(kl) < -1) m = '0;
      if (sat) m = SAT_MAG;
      s3_d = s2_q.zb ? s3_t'{q: s2_q.sa ? ~SAT_MAG : SAT_MAG, div0: 1'b1, sat: 1'b1}
           : s2_q.za ? s3_t'('0)
           : s3_t'{q: s2_q.sq ? ~m : m, div0: 1'b0, sat: sat};
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         if (ld1) v1_q <= in_valid;
         if (ld1 && in_valid) s1_q <= s1_d;
         if (ld2) v2_q <= v1_q;
         if (ld2 && v1_q) s2_q <= s2_d;
         if (ld3) v3_q <= v2_q;
         if (ld3 && v2_q) s3_q <= s3_d;
      end
endmodule

// File: tb/tb_log_approx_div.sv
// tb_log_approx_div: scoreboard bench for log_approx_div covering reset, directed
// cases, stall/backpressure, random streaming and mid-flight reset.
module tb_log_approx_div;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid, out_div0, out_sat;
   logic [31:0] in_a = '0;
   logic [15:0] in_b = '0, out_q;
   int          checks = 0, errors = 0;
   logic [17:0] sb[$];

`ifdef LOG_DIV_ROUND_EN
   localparam logic [15:0] Q_1_2 = 16'd1;
`else
   localparam logic [15:0] Q_1_2 = 16'd0;
`endif

   logic [31:0] da[10] = '{32'd100, 32'd1000, 32'd3, -32'sd100, 32'd5, -32'sd5,
                           32'h40000000, 32'd0, -32'sd1, 32'd1};
   logic [15:0] db[10] = '{16'd10, 16'd3, 16'd10, 16'd10, 16'd0, 16'd0,
                           16'd1, 16'd7, 16'd7, 16'd2};
   logic [17:0] de[10] = '{{16'd10, 2'b00}, {16'd352, 2'b00}, {16'd0, 2'b00},
                           {16'hFFF5, 2'b00}, {16'h7FFF, 2'b11}, {16'h8000, 2'b11},
                           {16'h7FFF, 2'b01}, {16'd0, 2'b00}, {16'd0, 2'b00},
                           {Q_1_2, 2'b00}};

   always #5 clk = ~clk;

   log_approx_div dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_q(out_q), .out_div0(out_div0), .out_sat(out_sat));

   function automatic int ilog2(input longint v);
      int k = 0;
      while ((v >> (k + 1)) != 0) k++;
      return k;
   endfunction

   function automatic int mant(input longint v);
      int k = ilog2(v);
      return int'(((k >= 4) ? (v >> (k - 4)) : (v << (4 - k))) & 15) | 1;
   endfunction

   // Arithmetic reference: {q, div0, sat}
   function automatic logic [17:0] model(input logic [31:0] a, input logic [15:0] b);
      longint ma, mb, m;
      int     l, kl, fl;
      logic   s;
      ma = a[31] ? -longint'($signed(a)) - 1 : longint'(a);
      mb = b[15] ? -longint'($signed(b)) - 1 : longint'(b);
      s  = a[31] ^ b[15];
      if (mb == 0) return {a[31] ? 16'h8000 : 16'h7FFF, 2'b11};
      if (ma == 0) return '0;
      l  = (ilog2(ma) * 16 + mant(ma)) - (ilog2(mb) * 16 + mant(mb));
      kl = l >>> 4;
      fl = l & 15;
`ifdef LOG_DIV_ROUND_EN
      m = (kl < -1 || kl >= 15) ? 0 : ((((longint'(16 + fl) << (kl + 1)) >> 4) + 1) >> 1);
`else
      m = (kl < 0 || kl >= 15) ? 0 : ((longint'(16 + fl) << kl) >> 4);
`endif
      if (kl >= 15 || m >= 32768) return {s ? 16'h8000 : 16'h7FFF, 2'b01};
      return {s ? ~m[15:0] : m[15:0], 2'b00};
   endfunction

   function automatic logic [31:0] rand_a();
      logic [31:0] x = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) return $urandom_range(0, 1) ? 32'hFFFFFFFF : 32'd0;
      return $urandom_range(0, 1) ? -x : x;
   endfunction

   function automatic logic [15:0] rand_b();
      logic [15:0] x = 16'($urandom()) >> $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0) return $urandom_range(0, 1) ? 16'hFFFF : 16'd0;
      return $urandom_range(0, 1) ? -x : x;
   endfunction

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, out_q, out_div0, out_sat} !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b q=%h d=%b s=%b want all 0", out_valid, out_q, out_div0, out_sat);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_directed;
      int          lat;
      logic [17:0] exp;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_a = da[i]; in_b = db[i]; out_ready = 1'b1;
         sb.push_back(de[i]);
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL directed_in_ready[%0d]: got %b want 1", i, in_ready);
         end
         @(negedge clk);
         in_valid = 1'b0;
         lat = 1;
         while (out_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
         end
         checks++;
         if (lat != 3) begin
            errors++;
            $display("FAIL directed_latency[%0d]: got %0d want 3", i, lat);
         end
         exp = sb.pop_front();
         checks++;
         if ({out_q, out_div0, out_sat} !== exp) begin
            errors++;
            $display("FAIL directed[%0d] a=%h b=%h: got q=%h d=%b s=%b want q=%h d=%b s=%b",
                     i, da[i], db[i], out_q, out_div0, out_sat, exp[17:2], exp[1], exp[0]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [31:0] ba[6] = '{32'd100, 32'd1000, -32'sd100, 32'd5, 32'h40000000, 32'd7};
      logic [15:0] bb[6] = '{16'd10, 16'd3, 16'd10, 16'd0, 16'd1, 16'd1};
      logic        saw_block = 1'b0;
      fork
         begin
            int sent = 0, guard = 0;
            while (sent < 6 && guard < 200) begin
               @(negedge clk);
               guard++;
               in_valid = 1'b1; in_a = ba[sent]; in_b = bb[sent];
               #1;
               if (!in_ready) saw_block = 1'b1;
               else begin
                  sb.push_back(model(ba[sent], bb[sent]));
                  sent++;
               end
            end
            @(negedge clk);
            in_valid = 1'b0;
         end
         begin
            int          got = 0, cyc = 0;
            logic        stalled = 1'b0;
            logic [17:0] held, exp;
            while (got < 6 && cyc < 200) begin
               @(negedge clk);
               cyc++;
               out_ready = !(cyc >= 4 && cyc <= 8);
               if (out_valid && !out_ready) begin
                  if (stalled) begin
                     checks++;
                     if ({out_q, out_div0, out_sat} !== held) begin
                        errors++;
                        $display("FAIL stall_hold cyc=%0d: got %h want %h", cyc, {out_q, out_div0, out_sat}, held);
                     end
                  end
                  held    = {out_q, out_div0, out_sat};
                  stalled = 1'b1;
               end else stalled = 1'b0;
               if (out_valid && out_ready) begin
                  exp = (sb.size() != 0) ? sb.pop_front() : 18'hx;
                  checks++;
                  if ({out_q, out_div0, out_sat} !== exp) begin
                     errors++;
                     $display("FAIL b2b[%0d]: got %h want %h", got, {out_q, out_div0, out_sat}, exp);
                  end
                  got++;
               end
            end
            checks++;
            if (got != 6) begin
               errors++;
               $display("FAIL b2b_count: got %0d want 6", got);
            end
         end
      join
      checks++;
      if (saw_block !== 1'b1) begin
         errors++;
         $display("FAIL b2b_in_ready_block: got %b want 1", saw_block);
      end
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL b2b_extra: got out_valid=%b pending=%0d want 0/0", out_valid, sb.size());
      end
   endtask

   task automatic test_random(input int n);
      fork
         begin
            int          sent = 0, guard = 0;
            logic [31:0] a = rand_a();
            logic [15:0] b = rand_b();
            while (sent < n && guard < 2000) begin
               @(negedge clk);
               guard++;
               in_valid = 1'b1; in_a = a; in_b = b;
               #1;
               if (in_ready) begin
                  sb.push_back(model(a, b));
                  sent++;
                  a = rand_a();
                  b = rand_b();
               end
            end
            @(negedge clk);
            in_valid = 1'b0;
         end
         begin
            int          got = 0, cyc = 0;
            logic [17:0] exp;
            while (got < n && cyc < 4000) begin
               @(negedge clk);
               cyc++;
               out_ready = ($urandom_range(0, 3) != 0);
               if (out_valid && out_ready) begin
                  exp = (sb.size() != 0) ? sb.pop_front() : 18'hx;
                  checks++;
                  if ({out_q, out_div0, out_sat} !== exp) begin
                     errors++;
                     $display("FAIL random[%0d]: got %h want %h", got, {out_q, out_div0, out_sat}, exp);
                  end
                  got++;
               end
            end
            checks++;
            if (got != n) begin
               errors++;
               $display("FAIL random_count: got %0d want %0d", got, n);
            end
         end
      join
      out_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_midflight;
      int lat = 0, seen = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_a = 32'd100; in_b = 16'd10;
      end
      @(negedge clk);
      in_valid = 1'b0;
      while (out_valid !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL midreset_setup: got out_valid=%b want 1", out_valid);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_q !== 16'd0) begin
         errors++;
         $display("FAIL midreset_clear: got v=%b q=%h want 0/0", out_valid, out_q);
      end
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL midreset_stale: got %0d outputs want 0", seen);
      end
      sb.delete();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random(60);
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
